// File: rtl/led_sequencer.sv
// led_sequencer: round-robin arbitrated LED blinker; each grant runs N tick-timed
// ON/OFF blinks followed by an enforced dark GAP, with all outputs registered.
module led_sequencer #(
  parameter int TICK_DIV  = 5,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] REQ,
  input  logic [3:0] CNT0,
  input  logic [3:0] CNT1,
  output logic [1:0] GNT,
  output logic       BUSY,
  output logic       DONE,
  output logic       LED0
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_ON = 2'd1, S_OFF = 2'd2, S_GAP = 2'd3;
  logic [1:0] state_q, state_d, gnt_q, gnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] tcnt_q, tcnt_d, lim;
  logic [3:0] rem_q, rem_d, cnt_sel;
  logic ptr_q, ptr_d, busy_q, done_q, done_d, led_q, tick, last, pick0;
  always_comb begin
    tick = presc_q == PW'(TICK_DIV - 1);
    lim = state_q == S_ON ? 8'(ON_TICKS - 1) : state_q == S_OFF ? 8'(OFF_TICKS - 1) : 8'(GAP_TICKS - 1);
    last = tick && tcnt_q == lim;
    // ptr_q holds the last-granted requester; requester 0 wins a tie only if 1 went last
    pick0 = REQ[0] && (!REQ[1] || ptr_q);
    cnt_sel = pick0 ? CNT0 : CNT1;
    state_d = state_q;
    presc_d = (state_q == S_IDLE || tick) ? '0 : presc_q + 1'b1;
    tcnt_d = state_q == S_IDLE ? '0 : tick ? tcnt_q + 8'd1 : tcnt_q;
    rem_d = rem_q;
    ptr_d = ptr_q;
    gnt_d = 2'b00;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (|REQ) begin
        gnt_d = pick0 ? 2'b01 : 2'b10;
        ptr_d = !pick0;
        rem_d = cnt_sel;
        state_d = cnt_sel == 4'd0 ? S_GAP : S_ON;
      end
      S_ON: if (last) begin
        rem_d = rem_q - 4'd1;
        state_d = rem_q == 4'd1 ? S_GAP : S_OFF;
      end
      S_OFF: if (last) state_d = S_ON;
      default: if (last) begin
        state_d = S_IDLE;
        done_d = 1'b1;
      end
    endcase
    if (last) tcnt_d = '0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q <= '0;
      rem_q <= '0;
      ptr_q <= 1'b1;
      gnt_q <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q <= tcnt_d;
      rem_q <= rem_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      busy_q <= state_d != S_IDLE;
      done_q <= done_d;
      led_q <= state_d == S_ON;
    end
  end
  assign GNT = gnt_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign LED0 = led_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed table-driven checks of two led_sequencer instances
// (default timing and a fully fast one) plus reset and round-robin sequences.
module tb_led_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] cnt0 = 4'd0, cnt1 = 4'd0;
  logic [1:0] req_a, req_b, gnt_a, gnt_b, gnt_m;
  logic busy_a, busy_b, done_a, done_b, led_a, led_b, busy_m, done_m, led_m;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign req_a = sel ? 2'b00 : req;
  assign req_b = sel ? req : 2'b00;
  assign gnt_m = sel ? gnt_b : gnt_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign led_m = sel ? led_b : led_a;

  led_sequencer dut_a (
    .CLK(clk), .RST_N(rst_n), .REQ(req_a), .CNT0(cnt0), .CNT1(cnt1),
    .GNT(gnt_a), .BUSY(busy_a), .DONE(done_a), .LED0(led_a)
  );

  led_sequencer #(.TICK_DIV(1), .ON_TICKS(1), .OFF_TICKS(1), .GAP_TICKS(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .REQ(req_b), .CNT0(cnt0), .CNT1(cnt1),
    .GNT(gnt_b), .BUSY(busy_b), .DONE(done_b), .LED0(led_b)
  );

  typedef struct {
    bit sel;
    logic [1:0] req;
    logic [3:0] c0, c1;
    logic [1:0] gnt;
    int busy, lit, blinks, last;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Requests, waits for the grant, then perturbs CNT0/CNT1 (xor 4) while busy and
  // profiles LED0/BUSY until IDLE, where DONE must be high and GNT low.
  task automatic run_chk(input bit hold, input logic [1:0] r, input logic [3:0] c0, c1,
                         input logic [1:0] eg, input int eb, el, ebl, elast);
    int n, b, l, bl, lst, bad;
    logic prev;
    logic [1:0] g;
    @(negedge clk);
    req = r;
    cnt0 = c0;
    cnt1 = c1;
    g = 2'b00;
    n = 0;
    while (g == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      g = gnt_m;
      n++;
    end
    chk("grant", int'(g), int'(eg));
    chk("grant_latency", n, 1);
    chk("grant_done_low", int'(done_m), 0);
    b = 0; l = 0; bl = 0; lst = 0; bad = 0; prev = 1'b0;
    while (busy_m && b < 1000) begin
      b++;
      l += int'(led_m);
      if (led_m && !prev) bl++;
      if (led_m) lst = b;
      prev = led_m;
      if (done_m || (b > 1 && gnt_m != 2'b00)) bad++;
      if (b == 1) begin
        @(negedge clk);
        if (!hold) req = 2'b00;
        cnt0 = c0 ^ 4'h4;
        cnt1 = c1 ^ 4'h4;
      end
      @(posedge clk); #1;
    end
    chk("busy_cycles", b, eb);
    chk("lit_cycles", l, el);
    chk("blinks", bl, ebl);
    chk("last_lit", lst, elast);
    chk("glitch_while_busy", bad, 0);
    chk("done_pulse", int'(done_m), 1);
    chk("idle_gnt_low", int'(gnt_m), 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{0, 2'b01, 4'd3, 4'd0, 2'b01, 70, 30, 3, 50};
    vecs[1] = '{0, 2'b10, 4'd9, 4'd0, 2'b10, 20, 0, 0, 0};
    vecs[2] = '{0, 2'b10, 4'd0, 4'd2, 2'b10, 50, 20, 2, 30};
    vecs[3] = '{0, 2'b01, 4'd1, 4'd5, 2'b01, 30, 10, 1, 10};
    vecs[4] = '{0, 2'b10, 4'd0, 4'd15, 2'b10, 310, 150, 15, 290};
    vecs[5] = '{1, 2'b01, 4'd2, 4'd0, 2'b01, 4, 2, 2, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_led", int'(led_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesting continuously: 0 first (pointer resets to 1), then alternate.
    run_chk(1, 2'b11, 4'd1, 4'd2, 2'b01, 30, 10, 1, 10);
    run_chk(1, 2'b11, 4'd1, 4'd2, 2'b10, 50, 20, 2, 30);
    run_chk(1, 2'b11, 4'd1, 4'd2, 2'b01, 30, 10, 1, 10);
    @(negedge clk);
    req = 2'b00;

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      run_chk(0, vecs[i].req, vecs[i].c0, vecs[i].c1, vecs[i].gnt,
              vecs[i].busy, vecs[i].lit, vecs[i].blinks, vecs[i].last);
    end
    @(negedge clk);
    sel = 1'b0;

    // Reset during the second ON of a 3-blink run aborts it asynchronously.
    begin
      int n;
      @(negedge clk);
      req = 2'b01;
      cnt0 = 4'd3;
      n = 0;
      while (gnt_a == 2'b00 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("abort_grant", int'(gnt_a), 1);
      repeat (24) @(posedge clk);
      #1;
      chk("abort_mid_on", int'(led_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_led_async", int'(led_a), 0);
      chk("abort_busy_async", int'(busy_a), 0);
      req = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", int'(done_a), 0);
      chk("abort_still_idle", int'(busy_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_chk(0, 2'b01, 4'd3, 4'd0, 2'b01, 70, 30, 3, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
